// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with write-back select and gated register-file write port.
// Define MEM_WB_RETIRE_CNT_EN to add the retireCount retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  inValid,
  input  logic [DATA_W-1:0]     ALUout,
  input  logic [DATA_W-1:0]     readMemoryData,
  input  logic [DATA_W-1:0]     pcPlus4,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  SIG_RegWrite,
  input  logic [1:0]            SIG_WBSel,
  output logic                  wbValid,
  output logic [DATA_W-1:0]     wbData,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  wbRegWrite
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retireCount
`endif
);
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d, wb_mux;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  we_q, we_d;
  always_comb begin
    wb_mux  = SIG_WBSel == 2'd0 ? ALUout :
              SIG_WBSel == 2'd1 ? readMemoryData :
              SIG_WBSel == 2'd2 ? pcPlus4 : '0;
    valid_d = flush ? 1'b0 : stall ? valid_q : inValid;
    data_d  = flush ? '0 : stall ? data_q : wb_mux;
    rd_d    = flush ? '0 : stall ? rd_q : rd;
    // bubbles and x0 destinations never write the register file
    we_d    = flush ? 1'b0 : stall ? we_q : inValid & SIG_RegWrite & (rd != '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end
  assign wbValid    = valid_q;
  assign wbData     = data_q;
  assign wbRd       = rd_q;
  assign wbRegWrite = we_q;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;
  always_comb retire_d = (!flush && !stall && inValid) ? retire_q + 32'd1 : retire_q;
  always_ff @(posedge clock) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end
  assign retireCount = retire_q;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
  logic        clock = 1'b0;
  logic        reset, stall, flush, inValid, SIG_RegWrite;
  logic [31:0] ALUout, readMemoryData, pcPlus4, wbData;
  logic [4:0]  rd, wbRd;
  logic [1:0]  SIG_WBSel;
  logic        wbValid, wbRegWrite;
  int          n_checks = 0;
  int          n_fails  = 0;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retireCount;
`endif
  always #5 clock = ~clock;
  mem_wb_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .inValid(inValid),
    .ALUout(ALUout), .readMemoryData(readMemoryData), .pcPlus4(pcPlus4), .rd(rd),
    .SIG_RegWrite(SIG_RegWrite), .SIG_WBSel(SIG_WBSel),
    .wbValid(wbValid), .wbData(wbData), .wbRd(wbRd), .wbRegWrite(wbRegWrite)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retireCount(retireCount)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                         input logic [4:0] r, input logic w);
    chk({tag, ".valid"}, {31'd0, wbValid}, {31'd0, v});
    chk({tag, ".data"}, wbData, d);
    chk({tag, ".rd"}, {27'd0, wbRd}, {27'd0, r});
    chk({tag, ".we"}, {31'd0, wbRegWrite}, {31'd0, w});
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] p, input logic [4:0] r, input logic w,
                       input logic [1:0] s);
    inValid = v; ALUout = a; readMemoryData = m; pcPlus4 = p;
    rd = r; SIG_RegWrite = w; SIG_WBSel = s;
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'hAAAA_5555, 32'h1, 32'h2, 5'd3, 1'b1, 2'd0);
    tick();
    chk_all("reset", 1'b0, 32'h0, 5'd0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'hFFFF_FF80, 32'h0000_0104, 5'd5, 1'b1, 2'd0);
    tick();
    chk_all("load_alu", 1'b1, 32'h1234, 5'd5, 1'b1);
    SIG_WBSel = 2'd1;
    tick();
    chk("sel_mem", wbData, 32'hFFFF_FF80);
    SIG_WBSel = 2'd2;
    tick();
    chk("sel_pc4", wbData, 32'h0000_0104);
    SIG_WBSel = 2'd3;
    tick();
    chk("sel_zero", wbData, 32'h0);
    drive(1'b1, 32'h0000_0042, 32'h0, 32'h0, 5'd0, 1'b1, 2'd0);
    tick();
    chk_all("x0", 1'b1, 32'h42, 5'd0, 1'b0);
    drive(1'b0, 32'h0000_0077, 32'h0, 32'h0, 5'd7, 1'b1, 2'd0);
    tick();
    chk_all("bubble", 1'b0, 32'h77, 5'd7, 1'b0);
    drive(1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 32'hBEEF_0000 + i, 32'h5, 32'h6, 5'd9 + i[4:0], 1'b0, i[1:0]);
      tick();
      chk_all("stall", 1'b1, 32'h1234, 5'd5, 1'b1);
    end
    stall = 1'b0;
    drive(1'b1, 32'hBEEF_0000, 32'h5, 32'h6, 5'd9, 1'b1, 2'd0);
    tick();
    chk_all("unstall", 1'b1, 32'hBEEF_0000, 5'd9, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk_all("flush_stall", 1'b0, 32'h0, 5'd0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    tick();
    chk_all("reload", 1'b1, 32'hBEEF_0000, 5'd9, 1'b1);
    reset = 1'b1; flush = 1'b1; stall = 1'b1;
    tick();
    chk_all("reset_flush", 1'b0, 32'h0, 5'd0, 1'b0);
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("retire_reset", retireCount, 32'd0);
    drive(1'b1, 32'h1, 32'h0, 32'h0, 5'd1, 1'b1, 2'd0);
    repeat (4) tick();
    stall = 1'b1; tick(); stall = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    inValid = 1'b0; tick();
    chk("retire_count", retireCount, 32'd4);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    chk("retire_preload", retireCount, 32'hFFFF_FFFF);
    inValid = 1'b1;
    tick();
    chk("retire_wrap", retireCount, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
